// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal-sync tree.
//   sd_e     : destination selector carried with responses
//              (bit 1 = left/south child, bit 0 = right/north child).
//   SD_NONE  : selector value with no destination; illegal on the
//              response path, such responses are dropped and counted.
//   sd_has_* : helpers decoding which children a selector targets.
package fractal_sync_pkg;

  typedef enum logic [1:0] {
    SD_RN   = 2'b01,
    SD_LS   = 2'b10,
    SD_BOTH = 2'b11
  } sd_e;

  localparam logic [1:0] SD_NONE = 2'b00;

  function automatic logic sd_has_ls(input logic [1:0] sd);
    return sd[1];
  endfunction

  function automatic logic sd_has_rn(input logic [1:0] sd);
    return sd[0];
  endfunction

endpackage

// File: rtl/fractal_sync_rsp_fifo.sv
// Generic synchronous FIFO with registered storage and head output.
//   clk, rst     : clock, synchronous active-high reset (empties FIFO)
//   push, wdata  : write request and data (ignored while full)
//   pop          : remove head (ignored while empty)
//   rdata        : current head entry (valid while !empty)
//   full, empty  : occupancy status from registered state
// DEPTH must be a power of two >= 2 so pointers wrap naturally.
module fractal_sync_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fractal_sync_rsp_fork.sv
// Response fork of a fractal-sync tree node: buffers barrier-release
// responses from the parent and routes each to the left/south child,
// the right/north child, or both, according to its sd selector.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   rsp_valid_i/rsp_ready_o   : parent-side handshake (ready = !full)
//   rsp_sd_i/level_i/id_i     : parent response payload
//   ls_valid_o/ls_ready_i     : left/south child handshake
//   ls_level_o/ls_id_o        : left/south payload (0 while not valid)
//   rn_valid_o/rn_ready_i     : right/north child handshake
//   rn_level_o/rn_id_o        : right/north payload (0 while not valid)
//   err_o                     : pulses in the cycle an illegal response drops
//   drop_cnt_o                : saturating count of dropped responses
module fractal_sync_rsp_fork
  import fractal_sync_pkg::*;
#(
  parameter int unsigned LVL_WIDTH  = 4,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [1:0]           rsp_sd_i,
  input  logic [LVL_WIDTH-1:0] rsp_level_i,
  input  logic [ID_WIDTH-1:0]  rsp_id_i,
  output logic                 ls_valid_o,
  input  logic                 ls_ready_i,
  output logic [LVL_WIDTH-1:0] ls_level_o,
  output logic [ID_WIDTH-1:0]  ls_id_o,
  output logic                 rn_valid_o,
  input  logic                 rn_ready_i,
  output logic [LVL_WIDTH-1:0] rn_level_o,
  output logic [ID_WIDTH-1:0]  rn_id_o,
  output logic                 err_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o
);

  typedef struct packed {
    logic [1:0]           sd;
    logic [LVL_WIDTH-1:0] level;
    logic [ID_WIDTH-1:0]  id;
  } rsp_t;

  rsp_t                 in_rsp;
  rsp_t                 head;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_valid;
  logic                 pend_ls;
  logic                 pend_rn;
  logic                 done_ls;
  logic                 done_rn;
  logic                 hs_ls;
  logic                 hs_rn;
  logic                 pop;
  logic                 drop;
  logic [CNT_WIDTH-1:0] drop_cnt;

  assign in_rsp = '{sd: rsp_sd_i, level: rsp_level_i, id: rsp_id_i};

  fractal_sync_rsp_fifo #(
    .WIDTH($bits(rsp_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (rsp_valid_i),
    .wdata (in_rsp),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rsp_ready_o = !fifo_full;
  assign head_valid  = !fifo_empty;

  // Pending is tracked as "targeted and not yet completed" so that a
  // fresh head starts with pend = sd bits without an extra load cycle.
  assign pend_ls = sd_has_ls(head.sd) && !done_ls;
  assign pend_rn = sd_has_rn(head.sd) && !done_rn;

  assign ls_valid_o = head_valid && pend_ls;
  assign rn_valid_o = head_valid && pend_rn;
  assign ls_level_o = ls_valid_o ? head.level : '0;
  assign ls_id_o    = ls_valid_o ? head.id    : '0;
  assign rn_level_o = rn_valid_o ? head.level : '0;
  assign rn_id_o    = rn_valid_o ? head.id    : '0;

  assign hs_ls = ls_valid_o && ls_ready_i;
  assign hs_rn = rn_valid_o && rn_ready_i;

  // An SD_NONE head has nothing pending, so it pops immediately.
  assign pop  = head_valid && (!pend_ls || ls_ready_i) && (!pend_rn || rn_ready_i);
  assign drop = head_valid && (head.sd == SD_NONE);

  assign err_o      = drop;
  assign drop_cnt_o = drop_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      done_ls  <= 1'b0;
      done_rn  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (pop) begin
        done_ls <= 1'b0;
        done_rn <= 1'b0;
      end else begin
        if (hs_ls) done_ls <= 1'b1;
        if (hs_rn) done_rn <= 1'b1;
      end
      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fractal_sync_rsp_fork.sv
module tb_fractal_sync_rsp_fork;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rsp_valid = 1'b0;
  logic       rsp_ready;
  logic [1:0] rsp_sd = 2'b00;
  logic [3:0] rsp_level = '0;
  logic [7:0] rsp_id = '0;
  logic       ls_valid, rn_valid;
  logic       ls_ready = 1'b0;
  logic       rn_ready = 1'b0;
  logic [3:0] ls_level, rn_level;
  logic [7:0] ls_id, rn_id;
  logic       err;
  logic [7:0] drop_cnt;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fractal_sync_rsp_fork #(
    .LVL_WIDTH(4),
    .ID_WIDTH(8),
    .FIFO_DEPTH(2),
    .CNT_WIDTH(8)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .rsp_valid_i(rsp_valid),
    .rsp_ready_o(rsp_ready),
    .rsp_sd_i(rsp_sd),
    .rsp_level_i(rsp_level),
    .rsp_id_i(rsp_id),
    .ls_valid_o(ls_valid),
    .ls_ready_i(ls_ready),
    .ls_level_o(ls_level),
    .ls_id_o(ls_id),
    .rn_valid_o(rn_valid),
    .rn_ready_i(rn_ready),
    .rn_level_o(rn_level),
    .rn_id_o(rn_id),
    .err_o(err),
    .drop_cnt_o(drop_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (ls_valid !== 1'b0) begin fails++; $display("FAIL reset_ls_valid got %0b want 0", ls_valid); end
    checks++; if (rn_valid !== 1'b0) begin fails++; $display("FAIL reset_rn_valid got %0b want 0", rn_valid); end
    checks++; if (rsp_ready !== 1'b1) begin fails++; $display("FAIL reset_rsp_ready got %0b want 1", rsp_ready); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err); end
    checks++; if (drop_cnt !== 8'd0) begin fails++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
    checks++; if ({ls_id, ls_level, rn_id, rn_level} !== 24'h0) begin fails++; $display("FAIL reset_payload got %h want 0", {ls_id, ls_level, rn_id, rn_level}); end
  endtask

  task automatic test_single();
    ls_ready = 1'b1; rn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_sd = 2'b10; rsp_level = 4'd3; rsp_id = 8'h5A;
    #1;
    checks++; if (ls_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %0b want 0", ls_valid); end
    step();
    rsp_valid = 1'b0;
    #1;
    checks++; if (ls_valid !== 1'b1) begin fails++; $display("FAIL single_ls_valid got %0b want 1", ls_valid); end
    checks++; if (ls_level !== 4'd3) begin fails++; $display("FAIL single_ls_level got %0d want 3", ls_level); end
    checks++; if (ls_id !== 8'h5A) begin fails++; $display("FAIL single_ls_id got %h want 5a", ls_id); end
    checks++; if (rn_valid !== 1'b0) begin fails++; $display("FAIL single_rn_valid got %0b want 0", rn_valid); end
    step();
    checks++; if (ls_valid !== 1'b0) begin fails++; $display("FAIL single_after_ls_valid got %0b want 0", ls_valid); end
    checks++; if (dut.fifo_empty !== 1'b1) begin fails++; $display("FAIL single_empty got %0b want 1", dut.fifo_empty); end
    ls_ready = 1'b0;
  endtask

  task automatic test_both();
    int ls_hs = 0;
    ls_ready = 1'b1; rn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_sd = 2'b11; rsp_level = 4'd1; rsp_id = 8'h11;
    step();
    rsp_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) rn_ready = 1'b1;
      #1;
      if (ls_valid && ls_ready) ls_hs++;
      checks++; if (rn_valid !== 1'b1 || rn_id !== 8'h11) begin fails++; $display("FAIL both_rn_hold[%0d] got v=%0b id=%h want v=1 id=11", k, rn_valid, rn_id); end
      checks++; if (ls_valid !== (k == 0)) begin fails++; $display("FAIL both_ls_valid[%0d] got %0b want %0b", k, ls_valid, (k == 0)); end
      checks++; if (dut.fifo_empty !== 1'b0) begin fails++; $display("FAIL both_not_popped[%0d] got empty=%0b want 0", k, dut.fifo_empty); end
      step();
    end
    checks++; if (ls_hs !== 1) begin fails++; $display("FAIL both_ls_hs_count got %0d want 1", ls_hs); end
    checks++; if (rn_valid !== 1'b0 || ls_valid !== 1'b0) begin fails++; $display("FAIL both_done_valids got ls=%0b rn=%0b want 0 0", ls_valid, rn_valid); end
    checks++; if (dut.fifo_empty !== 1'b1) begin fails++; $display("FAIL both_popped got empty=%0b want 1", dut.fifo_empty); end
    ls_ready = 1'b0; rn_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    ls_ready = 1'b0; rn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_sd = 2'b10; rsp_level = 4'd2;
    rsp_id = 8'd1; #1;
    checks++; if (rsp_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_1 got %0b want 1", rsp_ready); end
    step();
    rsp_id = 8'd2; #1;
    checks++; if (rsp_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_2 got %0b want 1", rsp_ready); end
    step();
    rsp_id = 8'd3; #1;
    checks++; if (rsp_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got %0b want 0", rsp_ready); end
    step();
    checks++; if (rsp_ready !== 1'b0 || ls_id !== 8'd1) begin fails++; $display("FAIL b2b_stall got rdy=%0b id=%0d want rdy=0 id=1", rsp_ready, ls_id); end
    ls_ready = 1'b1;
    step();
    checks++; if (ls_valid !== 1'b1 || ls_id !== 8'd2) begin fails++; $display("FAIL b2b_drain_2 got v=%0b id=%0d want v=1 id=2", ls_valid, ls_id); end
    checks++; if (rsp_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_after_pop got %0b want 1", rsp_ready); end
    step();
    rsp_valid = 1'b0;
    #1;
    checks++; if (ls_valid !== 1'b1 || ls_id !== 8'd3) begin fails++; $display("FAIL b2b_drain_3 got v=%0b id=%0d want v=1 id=3", ls_valid, ls_id); end
    step();
    checks++; if (ls_valid !== 1'b0 || dut.fifo_empty !== 1'b1) begin fails++; $display("FAIL b2b_empty got v=%0b empty=%0b want 0 1", ls_valid, dut.fifo_empty); end
    ls_ready = 1'b0;
  endtask

  task automatic test_illegal();
    int errs = 0;
    int bad_valid = 0;
    ls_ready = 1'b1; rn_ready = 1'b1;
    rsp_sd = 2'b00; rsp_level = 4'd7; rsp_id = 8'h77;
    for (int c = 0; c < 7; c++) begin
      rsp_valid = (c < 3);
      step();
      if (err === 1'b1) errs++;
      if (ls_valid !== 1'b0 || rn_valid !== 1'b0) bad_valid++;
    end
    checks++; if (errs !== 3) begin fails++; $display("FAIL illegal_err_pulses got %0d want 3", errs); end
    checks++; if (bad_valid !== 0) begin fails++; $display("FAIL illegal_child_valid got %0d cycles want 0", bad_valid); end
    checks++; if (drop_cnt !== 8'd3) begin fails++; $display("FAIL illegal_drop_cnt got %0d want 3", drop_cnt); end
    rsp_valid = 1'b1;
    for (int c = 0; c < 260; c++) step();
    checks++; if (err !== 1'b1 || drop_cnt !== 8'd255) begin fails++; $display("FAIL sat_during got err=%0b cnt=%0d want 1 255", err, drop_cnt); end
    rsp_valid = 1'b0;
    step();
    checks++; if (err !== 1'b0 || drop_cnt !== 8'd255) begin fails++; $display("FAIL sat_final got err=%0b cnt=%0d want 0 255", err, drop_cnt); end
    ls_ready = 1'b0; rn_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int stale = 0;
    ls_ready = 1'b1; rn_ready = 1'b0;
    rsp_valid = 1'b1; rsp_sd = 2'b11; rsp_level = 4'd5; rsp_id = 8'h21;
    step();
    rsp_sd = 2'b10; rsp_id = 8'h22;
    step();
    rsp_valid = 1'b0;
    #1;
    checks++; if (ls_valid !== 1'b0 || rn_valid !== 1'b1 || rn_id !== 8'h21) begin fails++; $display("FAIL mid_half_forked got ls=%0b rn=%0b id=%h want 0 1 21", ls_valid, rn_valid, rn_id); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if ({ls_valid, rn_valid, err, ls_id, ls_level, rn_id, rn_level} !== 27'h0) begin fails++; $display("FAIL mid_outputs got %h want 0", {ls_valid, rn_valid, err, ls_id, ls_level, rn_id, rn_level}); end
    checks++; if (rsp_ready !== 1'b1) begin fails++; $display("FAIL mid_ready got %0b want 1", rsp_ready); end
    rn_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (ls_valid !== 1'b0 || rn_valid !== 1'b0) stale++;
    end
    checks++; if (stale !== 0) begin fails++; $display("FAIL mid_stale got %0d cycles want 0", stale); end
    ls_ready = 1'b0; rn_ready = 1'b0;
  endtask

  task automatic test_stream();
    int ls_n = 0;
    int rn_n = 0;
    int bad = 0;
    logic [7:0] want_id;
    ls_ready = 1'b1; rn_ready = 1'b1;
    for (int c = 0; c < 18; c++) begin
      rsp_valid = (c < 16);
      rsp_sd = (c % 2 == 0) ? 2'b01 : 2'b10;
      rsp_id = 8'h40 + 8'(c);
      rsp_level = 4'(c);
      #1;
      if (c < 16 && rsp_ready !== 1'b1) bad++;
      step();
      want_id = 8'h40 + 8'(c);
      if (ls_valid && ls_ready) ls_n++;
      if (rn_valid && rn_ready) rn_n++;
      if (c < 16) begin
        if (c % 2 == 0) begin
          if (rn_valid !== 1'b1 || rn_id !== want_id || rn_level !== 4'(c) || ls_valid !== 1'b0) bad++;
        end else begin
          if (ls_valid !== 1'b1 || ls_id !== want_id || ls_level !== 4'(c) || rn_valid !== 1'b0) bad++;
        end
      end else if (ls_valid !== 1'b0 || rn_valid !== 1'b0) begin
        bad++;
      end
    end
    checks++; if (bad !== 0) begin fails++; $display("FAIL stream_order got %0d bad cycles want 0", bad); end
    checks++; if (ls_n !== 8) begin fails++; $display("FAIL stream_ls_count got %0d want 8", ls_n); end
    checks++; if (rn_n !== 8) begin fails++; $display("FAIL stream_rn_count got %0d want 8", rn_n); end
    ls_ready = 1'b0; rn_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_both();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/fractal_sync_rsp_fork.md
Name: fractal_sync_rsp_fork

Overview:
- Downward (response) half of a fractal-sync tree node: takes barrier-release responses arriving from the parent level and routes them to the left/south child, the right/north child, or both, as selected by the response's sd_e field.
- Counterpart of the upward request-aggregation path. Sits between a node's parent-side response port and its two child-side response ports.
- Buffers responses in a small FIFO and forks SD_BOTH responses with independent per-branch handshakes.

Parameters:
- LVL_WIDTH, 4: width of the tree-level field carried with each response.
- ID_WIDTH, 8: width of the barrier identifier.
- FIFO_DEPTH, 2: input buffer entries; power of two, ≥2.
- CNT_WIDTH, 8: width of the illegal-response drop counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- rsp_valid_i  in  1  parent response valid.
- rsp_ready_o  out  1  parent response accepted.
- rsp_sd_i  in  2  fractal_sync_pkg::sd_e destination selector.
- rsp_level_i  in  LVL_WIDTH  level at which the barrier resolved.
- rsp_id_i  in  ID_WIDTH  barrier id.
- ls_valid_o / ls_ready_i  out / in  1  left/south child handshake.
- ls_level_o / ls_id_o  out  LVL_WIDTH / ID_WIDTH  left/south payload.
- rn_valid_o / rn_ready_i  out / in  1  right/north child handshake.
- rn_level_o / rn_id_o  out  LVL_WIDTH / ID_WIDTH  right/north payload.
- err_o  out  1  one-cycle pulse when an illegal response is dropped.
- drop_cnt_o  out  CNT_WIDTH  saturating count of dropped illegal responses.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high on rst_i.
- Reset values: FIFO empty; all valids 0; payload outputs 0; err_o 0; drop_cnt_o 0; branch-pending flags 0.
- Reset mid-operation flushes all buffered and partially forked responses. No output is replayed after reset.
- Input handshake:
  - rsp_ready_o = !full. This is registered-state combinational; there is no pop-through when full.
  - Push occurs when rsp_valid_i && rsp_ready_o. All fields are stored unchanged.
- Latency: an entry pushed in cycle N is visible at the head in N+1. Minimum input-to-output latency is 1 cycle; there is no bypass.
- Head dispatch:
  - When a new entry becomes head, pend_ls := sd[1] and pend_rn := sd[0].
  - ls_valid_o = head_valid && pend_ls. rn_valid_o = head_valid && pend_rn.
  - Both outputs carry the head's level and id. Payload is 0 when the corresponding valid is low.
  - A handshake on a branch clears that branch's pend flag.
  - The head pops in the cycle where every remaining pending branch completes its handshake. Both may complete in the same cycle.
  - Pop and push may occur in the same cycle when not full.
  - Once asserted, valid and payload on a branch stay stable until that branch's ready. A completed branch never re-asserts for the same entry.
- SD_BOTH: the branches are independent. Example: ls accepts in cycle N, rn in N+3 → ls_valid_o deasserts from N+1, head pops at end of N+3.
- Throughput: 1 response/cycle when all targeted readies are high.
- Illegal sd 2'b00: accepted into the FIFO; at the head it pops in 1 cycle with no output valid. err_o pulses in that cycle; drop_cnt_o increments and saturates at all-ones.
- FIFO pointers: wrap modulo FIFO_DEPTH. A count of FIFO_DEPTH+1 states distinguishes full from empty.

Decomposition:
- fractal_sync_pkg: reuse sd_e. Add localparam SD_NONE = 2'b00, documented as illegal on the response path.
- Response payload struct macro (level, id, sd) goes into include/typedef.svh alongside the existing typedef macros.
- One sub-module: fractal_sync_rsp_fifo, a generic FIFO with push/pop/full/empty and head output. The fork logic, pending flags and drop counter stay in the top module.

Test Plan:
- Reset then single push (sd=2'b10, level=3, id=0x5A), ls_ready_i=1 → ls_valid_o=1 one cycle after push, carrying level 3 / id 0x5A; rn_valid_o stays 0; FIFO empty afterwards.
- Push sd=2'b11, id=0x11; ls_ready_i=1, rn_ready_i=0 for 3 cycles, then 1 → ls handshake once; rn_valid_o held 4 cycles with id 0x11; head pops only after the rn handshake.
- Back-to-back pushes of ids 1,2,3 with both readies low → rsp_ready_o=0 after 2 accepted. Raising ls_ready_i (all sd=2'b10) drains 1,2 in order; id 3 is then accepted.
- Push sd=2'b00 three times → err_o pulses 3 times, drop_cnt_o=3, no child valid. Preload the counter near saturation with 260 drops → drop_cnt_o=255.
- Assert rst_i while an SD_BOTH entry is half-forked and a second entry is queued → the next cycle shows all outputs 0, rsp_ready_o=1, and no stale response afterwards.
- Streaming: 16 responses alternating sd 2'b01/2'b10, both readies high → one output handshake per cycle after 1-cycle latency; order and ids preserved per branch.
